// File: rtl/ldpc_status_monitor.sv
`default_nettype none
// ============================================================================
// ldpc_status_monitor : LDPC decoder status statistics with block limit & snapshot
// Revision 1.0
// ============================================================================
module ldpc_status_monitor #(
  parameter int BLK_W = 64,
  parameter int ERR_W = 32,
  parameter int SUM_W = 48
) (
  input  logic             data_clk,
  input  logic             data_resetn,
  input  logic             en,
  input  logic             clear,
  input  logic [BLK_W-1:0] block_limit,
  input  logic [31:0]      s_axis_status_tdata,
  input  logic             s_axis_status_tvalid,
  output logic             s_axis_status_tready,
  output logic [BLK_W-1:0] finished_blocks,
  output logic [ERR_W-1:0] failed_blocks,
  output logic [SUM_W-1:0] iter_sum,
  output logic [7:0]       iter_max,
  output logic             done,
  input  logic             snap_req,
  output logic             snap_valid,
  output logic [BLK_W-1:0] snap_finished,
  output logic [ERR_W-1:0] snap_failed,
  output logic [SUM_W-1:0] snap_iter_sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         rst_sync_q, rst_sync_d;
  logic [BLK_W-1:0]   finished_q, finished_d;
  logic [ERR_W-1:0]   failed_q, failed_d;
  logic [SUM_W-1:0]   iter_sum_q, iter_sum_d;
  logic [7:0]         iter_max_q, iter_max_d;
  logic               done_q, done_d;
  logic               snap_valid_q, snap_valid_d;
  logic [BLK_W-1:0]   snap_finished_q, snap_finished_d;
  logic [ERR_W-1:0]   snap_failed_q, snap_failed_d;
  logic [SUM_W-1:0]   snap_iter_sum_q, snap_iter_sum_d;

  logic               limit_hit;
  logic               tready;
  logic               accept;
  logic [7:0]         iter_used;
  logic               pass_flag;
  logic [SUM_W:0]     sum_ext;
  logic               unused_tdata;

  assign iter_used    = s_axis_status_tdata[7:0];
  assign pass_flag    = s_axis_status_tdata[8];
  assign unused_tdata = ^s_axis_status_tdata[31:9];

  // Limit check uses the registered count so tready drops the cycle after the last accept
  assign limit_hit = (block_limit != '0) && (finished_q >= block_limit);
  assign tready    = (state_q == RUN) && en && !clear && !limit_hit;
  assign accept    = s_axis_status_tvalid && tready;
  assign sum_ext   = {1'b0, iter_sum_q} + (SUM_W+1)'(iter_used);

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    state_d    = state_q;
    case (state_q)
      IDLE: if (en && rst_sync_q[1]) state_d = RUN;
      RUN: begin
        if (limit_hit)  state_d = DONE;
        else if (!en)   state_d = IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
    done_d = (state_d == DONE);
  end

  always_comb begin
    finished_d = finished_q;
    failed_d   = failed_q;
    iter_sum_d = iter_sum_q;
    iter_max_d = iter_max_q;
    if (clear) begin
      finished_d = '0;
      failed_d   = '0;
      iter_sum_d = '0;
      iter_max_d = '0;
    end else if (accept) begin
      if (finished_q != '1) finished_d = finished_q + BLK_W'(1);
      if (!pass_flag && (failed_q != '1)) failed_d = failed_q + ERR_W'(1);
      iter_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      if (iter_used > iter_max_q) iter_max_d = iter_used;
    end
  end

  // Snapshot captures the post-update values so a coincident accept is included
  always_comb begin
    snap_valid_d    = 1'b0;
    snap_finished_d = snap_finished_q;
    snap_failed_d   = snap_failed_q;
    snap_iter_sum_d = snap_iter_sum_q;
    if (clear) begin
      snap_finished_d = '0;
      snap_failed_d   = '0;
      snap_iter_sum_d = '0;
    end else if (snap_req) begin
      snap_valid_d    = 1'b1;
      snap_finished_d = finished_d;
      snap_failed_d   = failed_d;
      snap_iter_sum_d = iter_sum_d;
    end
  end

  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      rst_sync_q      <= '0;
      state_q         <= IDLE;
      finished_q      <= '0;
      failed_q        <= '0;
      iter_sum_q      <= '0;
      iter_max_q      <= '0;
      done_q          <= 1'b0;
      snap_valid_q    <= 1'b0;
      snap_finished_q <= '0;
      snap_failed_q   <= '0;
      snap_iter_sum_q <= '0;
    end else begin
      rst_sync_q      <= rst_sync_d;
      state_q         <= state_d;
      finished_q      <= finished_d;
      failed_q        <= failed_d;
      iter_sum_q      <= iter_sum_d;
      iter_max_q      <= iter_max_d;
      done_q          <= done_d;
      snap_valid_q    <= snap_valid_d;
      snap_finished_q <= snap_finished_d;
      snap_failed_q   <= snap_failed_d;
      snap_iter_sum_q <= snap_iter_sum_d;
    end
  end

  assign s_axis_status_tready = tready;
  assign finished_blocks      = finished_q;
  assign failed_blocks        = failed_q;
  assign iter_sum             = iter_sum_q;
  assign iter_max             = iter_max_q;
  assign done                 = done_q;
  assign snap_valid           = snap_valid_q;
  assign snap_finished        = snap_finished_q;
  assign snap_failed          = snap_failed_q;
  assign snap_iter_sum        = snap_iter_sum_q;

endmodule
`default_nettype wire

// File: doc/ldpc_status_monitor.md
LDPC_STATUS_MONITOR -- requirements
Module: ldpc_status_monitor

Interface
REQ-001 SHALL have parameter BLK_W, default 64: width of block counters and block_limit.
REQ-002 SHALL have parameter ERR_W, default 32: width of failed-block counter.
REQ-003 SHALL have parameter SUM_W, default 48: width of iteration accumulator.
REQ-004 SHALL have port data_clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port data_resetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have port en  in  1  run enable, level.
REQ-007 SHALL have port clear  in  1  synchronous one-cycle clear pulse.
REQ-008 SHALL have port block_limit  in  BLK_W  stop after this many blocks; 0 = unlimited.
REQ-009 SHALL have port s_axis_status_tdata  in  32  decoder status word: [7:0] iterations used, [8] pass flag (1 = parity OK), [31:9] ignored.
REQ-010 SHALL have port s_axis_status_tvalid  in  1  status word valid.
REQ-011 SHALL have port s_axis_status_tready  out  1  status word accepted.
REQ-012 SHALL have ports finished_blocks  out  BLK_W; failed_blocks  out  ERR_W; iter_sum  out  SUM_W; iter_max  out  8 (live counters).
REQ-013 SHALL have port done  out  1  block_limit reached.
REQ-014 SHALL have ports snap_req  in  1; snap_valid  out  1; snap_finished  out  BLK_W; snap_failed  out  ERR_W; snap_iter_sum  out  SUM_W (coherent snapshot).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE->RUN when en=1; RUN->IDLE when en=0, counters held; DONE->IDLE only on clear.
REQ-017 s_axis_status_tready SHALL equal (state==RUN) & en & ~clear, combinationally; 0 in IDLE and DONE.
REQ-018 Accept = tvalid & tready; each accept, registered next edge: finished_blocks +1; failed_blocks +1 if tdata[8]=0; iter_sum += tdata[7:0] (zero-extended); iter_max = max(iter_max, tdata[7:0]).
REQ-019 All counters SHALL saturate at all-ones; no wrap.
REQ-020 In RUN with block_limit!=0, when the registered finished_blocks >= block_limit the FSM SHALL enter DONE next edge; an accept making finished_blocks equal to block_limit SHALL drive tready low from the cycle after, so exactly block_limit words are accepted.
REQ-021 block_limit lowered below finished_blocks during RUN SHALL give DONE on the next edge with no further accepts.
REQ-022 done SHALL be registered, 1 exactly while state==DONE.
REQ-023 clear SHALL zero finished_blocks, failed_blocks, iter_sum, iter_max, snap_* data and snap_valid, and force state IDLE on the next edge from any state; clear has priority over any accept (tready already 0).
REQ-024 snap_req SHALL copy counter values post-update of that same cycle (including any accept that cycle) into snap_finished/snap_failed/snap_iter_sum, with snap_valid a one-cycle pulse on the following cycle; snapshot data held until next snap_req or clear.
REQ-025 snap_req and clear in same cycle: clear wins, snap_valid stays 0.
REQ-026 snap_req SHALL be honoured in any FSM state.
REQ-027 Latency status accept -> counter visible: 1 cycle.

Reset
REQ-028 data_resetn low SHALL asynchronously force state IDLE, tready 0, done 0, snap_valid 0, all counters and snapshot outputs 0.
REQ-029 Deassertion SHALL be synchronised internally to data_clk before FSM leaves IDLE; reset mid-transfer discards the word in flight.
REQ-030 No output SHALL be X after reset while en/clear/snap_req are driven.

Verification
REQ-031 limit=5, en=1, tvalid held with tdata=0x103 -> exactly 5 accepts, finished=5, failed=0, iter_sum=15, iter_max=3, done=1, tready=0 thereafter.
REQ-032 limit=0, words 0x00A, 0x105, 0x014 -> finished=3, failed=2, iter_sum=35, iter_max=20, done stays 0.
REQ-033 counters preloaded so failed_blocks=0xFFFFFFFF, one more fail word -> failed stays 0xFFFFFFFF, finished increments.
REQ-034 snap_req coincident with accept of 0x102 at finished=7 -> next cycle snap_valid=1, snap_finished=8.
REQ-035 In DONE pulse clear with snap_req and tvalid=1 -> next cycle state IDLE, all counters 0, snap_valid 0, no accept.
REQ-036 data_resetn asserted mid-RUN with tvalid=1 -> tready 0 immediately, all outputs 0; after release and en=1 counting restarts from 0.
